// File: rtl/msrh_rob_param.sv
// In-order reorder buffer of dispatch groups with wrap-bit pointers, backpressure and
// a kill drain that retires every group younger than a flushing commit as dead.
module msrh_rob_param #(
    parameter int DEPTH      = 8,
    parameter int GRP_W      = 4,
    parameter int DONE_PORTS = 3,
    parameter int TAG_W      = 16,
    parameter int EXC_W      = 5,
    parameter int VADDR_W    = 39,
    localparam int ID_W      = $clog2(DEPTH) + 1
) (
    input  logic                          i_clk,
    input  logic                          i_reset_n,
    input  logic                          i_disp_valid,
    output logic                          o_disp_ready,
    input  logic [GRP_W-1:0]              i_disp_grp_valid,
    input  logic [GRP_W*TAG_W-1:0]        i_disp_tag,
    output logic [ID_W-1:0]               o_disp_cmt_id,
    input  logic [DONE_PORTS-1:0]         i_done_valid,
    input  logic [DONE_PORTS*ID_W-1:0]    i_done_cmt_id,
    input  logic [DONE_PORTS*GRP_W-1:0]   i_done_lane_oh,
    input  logic [DONE_PORTS-1:0]         i_done_excpt,
    input  logic [DONE_PORTS*EXC_W-1:0]   i_done_excpt_type,
    input  logic [DONE_PORTS-1:0]         i_done_br_upd,
    input  logic [DONE_PORTS*VADDR_W-1:0] i_done_br_vaddr,
    output logic                          o_cmt_valid,
    output logic                          o_cmt_all_dead,
    output logic [ID_W-1:0]               o_cmt_id,
    output logic [GRP_W-1:0]              o_cmt_grp_valid,
    output logic [GRP_W*TAG_W-1:0]        o_cmt_tag,
    output logic [GRP_W-1:0]              o_cmt_dead_oh,
    output logic                          o_cmt_flush,
    output logic                          o_cmt_excpt,
    output logic [EXC_W-1:0]              o_cmt_excpt_type,
    output logic [VADDR_W-1:0]            o_cmt_flush_vaddr,
    output logic [ID_W-1:0]               o_count
);
    localparam int IDX_W = ID_W - 1;
    localparam int LW    = $clog2(GRP_W);

    typedef enum logic {IDLE, KILL} state_t;
    state_t r_state;

    logic [ID_W-1:0]  r_in_ptr, r_out_ptr, w_count;
    logic [IDX_W-1:0] w_in_idx, w_out_idx;

    logic                           r_valid    [DEPTH];
    logic [ID_W-1:0]                r_id       [DEPTH];
    logic [GRP_W-1:0]               r_grp_valid[DEPTH];
    logic [GRP_W*TAG_W-1:0]         r_tag      [DEPTH];
    logic [GRP_W-1:0]               r_done     [DEPTH];
    logic [GRP_W-1:0]               r_excpt    [DEPTH];
    logic [GRP_W-1:0]               r_br       [DEPTH];
    logic [GRP_W-1:0][EXC_W-1:0]    r_etype    [DEPTH];
    logic [GRP_W-1:0][VADDR_W-1:0]  r_bvaddr   [DEPTH];

    logic             w_full, w_accept, w_cmt_valid, w_all_dead, w_retire;
    logic [GRP_W-1:0] w_ev, w_dead;
    logic             w_seen;
    logic [LW-1:0]    w_first;
    logic [DONE_PORTS-1:0] w_hit;
    logic [IDX_W-1:0] w_didx [DONE_PORTS];

    assign w_in_idx  = r_in_ptr[IDX_W-1:0];
    assign w_out_idx = r_out_ptr[IDX_W-1:0];
    assign w_count   = r_in_ptr - r_out_ptr;
    assign w_full    = (w_in_idx == w_out_idx) && (r_in_ptr[IDX_W] != r_out_ptr[IDX_W]);

    assign o_disp_ready  = !w_full && (r_state == IDLE);
    assign w_accept      = i_disp_valid && o_disp_ready;
    assign o_disp_cmt_id = r_in_ptr;
    assign o_count       = w_count;

    assign w_cmt_valid = (r_state == IDLE) && r_valid[w_out_idx] && (&r_done[w_out_idx]);
    assign w_all_dead  = (r_state == KILL) && (w_count != '0);
    assign w_retire    = w_cmt_valid || w_all_dead;

    // Lanes after the first excpt/br lane are dead; the event lane itself still commits.
    always_comb begin
        w_ev    = r_excpt[w_out_idx] | r_br[w_out_idx];
        w_dead  = '0;
        w_seen  = 1'b0;
        w_first = '0;
        for (int l = 0; l < GRP_W; l++) begin
            w_dead[l] = w_seen;
            if (w_ev[l] && !w_seen) w_first = LW'(l);
            w_seen = w_seen | w_ev[l];
        end
    end

    assign o_cmt_valid       = w_cmt_valid;
    assign o_cmt_all_dead    = w_all_dead;
    assign o_cmt_id          = r_out_ptr;
    assign o_cmt_grp_valid   = w_retire ? r_grp_valid[w_out_idx] : '0;
    assign o_cmt_tag         = w_retire ? r_tag[w_out_idx] : '0;
    assign o_cmt_dead_oh     = w_all_dead ? r_grp_valid[w_out_idx] : (w_cmt_valid ? w_dead : '0);
    assign o_cmt_flush       = w_cmt_valid && w_seen;
    assign o_cmt_excpt       = o_cmt_flush && r_excpt[w_out_idx][w_first];
    assign o_cmt_excpt_type  = o_cmt_flush ? r_etype[w_out_idx][w_first] : '0;
    assign o_cmt_flush_vaddr = (o_cmt_flush && !o_cmt_excpt) ? r_bvaddr[w_out_idx][w_first] : '0;

    // A report must match a live entry's full id (wrap bit included) and not hit the retiring head.
    always_comb begin
        for (int p = 0; p < DONE_PORTS; p++) begin
            w_didx[p] = i_done_cmt_id[p*ID_W +: IDX_W];
            w_hit[p]  = i_done_valid[p] && (r_state == IDLE) && r_valid[w_didx[p]] &&
                        (r_id[w_didx[p]] == i_done_cmt_id[p*ID_W +: ID_W]) &&
                        !(w_retire && (w_didx[p] == w_out_idx));
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state   <= IDLE;
            r_in_ptr  <= '0;
            r_out_ptr <= '0;
            for (int e = 0; e < DEPTH; e++) r_valid[e] <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (o_cmt_flush && (w_count > ID_W'(1))) r_state <= KILL;
                KILL: if ((w_count == '0) || ((w_count == ID_W'(1)) && w_retire)) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase

            if (w_retire) begin
                r_valid[w_out_idx] <= 1'b0;
                r_out_ptr          <= r_out_ptr + ID_W'(1);
            end

            // Descending port order so the lowest port's payload lands last and wins.
            for (int p = DONE_PORTS - 1; p >= 0; p--) begin
                if (w_hit[p]) begin
                    for (int l = 0; l < GRP_W; l++) begin
                        if (i_done_lane_oh[p*GRP_W + l]) begin
                            r_done  [w_didx[p]][l] <= 1'b1;
                            r_excpt [w_didx[p]][l] <= i_done_excpt[p];
                            r_br    [w_didx[p]][l] <= i_done_br_upd[p];
                            r_etype [w_didx[p]][l] <= i_done_excpt_type[p*EXC_W +: EXC_W];
                            r_bvaddr[w_didx[p]][l] <= i_done_br_vaddr[p*VADDR_W +: VADDR_W];
                        end
                    end
                end
            end

            if (w_accept) begin
                r_valid    [w_in_idx] <= 1'b1;
                r_id       [w_in_idx] <= r_in_ptr;
                r_grp_valid[w_in_idx] <= i_disp_grp_valid;
                r_tag      [w_in_idx] <= i_disp_tag;
                r_done     [w_in_idx] <= ~i_disp_grp_valid;
                r_excpt    [w_in_idx] <= '0;
                r_br       [w_in_idx] <= '0;
                r_in_ptr              <= r_in_ptr + ID_W'(1);
            end
        end
    end
endmodule
